// File: rtl/ex_mem_skid_if.sv
// EX/MEM handshake bundle: execute-side request/ready and memory-side valid/ready
// with the pipeline payload carried in both directions.
interface ex_mem_skid_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic [DATA_W-1:0] in_store_data;
    logic [RD_W-1:0]   in_rd;
    logic [3:0]        in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [DATA_W-1:0] out_store_data;
    logic [RD_W-1:0]   out_rd;
    logic [3:0]        out_ctrl;

    modport slave (
        input  in_valid, in_result, in_zero, in_store_data, in_rd, in_ctrl,
        output in_ready,
        output out_valid, out_result, out_zero, out_store_data, out_rd, out_ctrl,
        input  out_ready
    );

    modport master (
        output in_valid, in_result, in_zero, in_store_data, in_rd, in_ctrl,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_store_data, out_rd, out_ctrl,
        output out_ready
    );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register with a one-entry skid buffer so in_ready is fully registered.
// Optional back-pressure counter enabled by defining EXMEM_STALL_CNT_EN.
module ex_mem_skid #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    ex_mem_skid_if.slave        bus,
    output logic [15:0]         stall_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd;
        logic [3:0]        ctrl;
    } entry_t;

    // Occupancy: main holds the presented entry, FULL means skid is also in use.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e   occ_q, occ_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   accept;
    logic   drain;

    assign in_ent = {bus.in_result, bus.in_zero, bus.in_store_data, bus.in_rd, bus.in_ctrl};

    assign bus.in_ready  = (occ_q != OCC_FULL);
    assign bus.out_valid = (occ_q != OCC_EMPTY);

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_d = in_ent;
                    occ_d  = OCC_MAIN;
                end
            end
            OCC_MAIN: begin
                if (drain && accept) begin
                    main_d = in_ent;
                end else if (drain) begin
                    occ_d = OCC_EMPTY;
                end else if (accept) begin
                    skid_d = in_ent;
                    occ_d  = OCC_FULL;
                end
            end
            OCC_FULL: begin
                if (drain) begin
                    main_d = skid_q;
                    occ_d  = OCC_MAIN;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        // Data may still load during a flush; it is unreachable once occupancy is empty.
        if (flush) begin
            occ_d = OCC_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.out_result     = main_q.result;
    assign bus.out_zero       = main_q.zero;
    assign bus.out_store_data = main_q.store_data;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_ctrl       = main_q.ctrl;

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.out_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: stimulus pushes expected entries, a negedge
// monitor pops and compares on every handshake and checks hold stability.
module tb_ex_mem_skid;
    localparam int DATA_W = 64;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd;
        logic [3:0]        ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] stall_cnt;

    ex_mem_skid_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bif ();

    ex_mem_skid #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bif),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ent_t mk(input logic [63:0] r, input logic z, input logic [63:0] s,
                                input logic [4:0] rd, input logic [3:0] c);
        ent_t e;
        e.result = r; e.zero = z; e.store_data = s; e.rd = rd; e.ctrl = c;
        return e;
    endfunction

    function automatic ent_t cur_out();
        return {bif.out_result, bif.out_zero, bif.out_store_data, bif.out_rd, bif.out_ctrl};
    endfunction

    // Monitor: pops on drain, and requires the presented entry to hold while stalled.
    ent_t prev_out;
    logic hold_prev = 1'b0;
    always @(negedge clk) begin
        ent_t c, e;
        c = cur_out();
        if (bif.out_valid && hold_prev) begin
            checks++;
            if (c !== prev_out) begin
                failures++;
                $display("FAIL hold_stable: got %h expected %h", c, prev_out);
            end
        end
        if (bif.out_valid && bif.out_ready && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got %h expected none", c);
            end else begin
                e = exp_q.pop_front();
                if (c !== e) begin
                    failures++;
                    $display("FAIL out_entry: got %h expected %h", c, e);
                end
            end
        end
        hold_prev = bif.out_valid && !bif.out_ready && !flush && !reset;
        prev_out  = c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ent_t e);
        bif.in_valid      = 1'b1;
        bif.in_result     = e.result;
        bif.in_zero       = e.zero;
        bif.in_store_data = e.store_data;
        bif.in_rd         = e.rd;
        bif.in_ctrl       = e.ctrl;
    endtask

    task automatic send(input ent_t e);
        drive(e);
        exp_q.push_back(e);
    endtask

    task automatic idle_in();
        bif.in_valid = 1'b0;
    endtask

    task automatic chk_empty_state(input string tag);
        chk({tag, "_out_valid"}, 64'(bif.out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(bif.in_ready),  64'd1);
    endtask

    initial begin
        ent_t a, b;
        reset = 1'b1; flush = 1'b0;
        bif.in_valid = 1'b0; bif.in_result = '0; bif.in_zero = 1'b0;
        bif.in_store_data = '0; bif.in_rd = '0; bif.in_ctrl = '0; bif.out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk_empty_state("rst");
        chk("rst_out_result", bif.out_result, 64'd0);
        chk("rst_out_store",  bif.out_store_data, 64'd0);
        chk("rst_out_rd_ctrl_zero", 64'({bif.out_rd, bif.out_ctrl, bif.out_zero}), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Single transfer: result visible the cycle after acceptance
        bif.out_ready = 1'b1;
        send(mk(64'h5, 1'b0, 64'h0, 5'd0, 4'h0));
        tick(); idle_in();
        chk("single_out_valid", 64'(bif.out_valid), 64'd1);
        chk("single_out_result", bif.out_result, 64'h5);
        chk("single_in_ready", 64'(bif.in_ready), 64'd1);
        tick();
        chk("single_after_out_valid", 64'(bif.out_valid), 64'd0);

        // Back-to-back stream of 8 with varied fields; zero flag passes through untouched
        for (int i = 1; i <= 8; i++) begin
            send(mk(64'(i), i[0], ~64'(i), 5'(i * 3), 4'(i)));
            tick();
            chk("stream_out_valid", 64'(bif.out_valid), 64'd1);
            chk("stream_in_ready", 64'(bif.in_ready), 64'd1);
        end
        idle_in();
        tick();
        chk("stream_end_out_valid", 64'(bif.out_valid), 64'd0);

        // Back-pressure fills skid; drain order A then B
        bif.out_ready = 1'b0;
        a = mk(64'hA, 1'b1, 64'h1111, 5'd10, 4'b1010);
        b = mk(64'hB, 1'b0, 64'h2222, 5'd11, 4'b0101);
        send(a);
        tick();
        chk("bp_in_ready_a", 64'(bif.in_ready), 64'd1);
        send(b);
        tick(); idle_in();
        chk("bp_in_ready_b", 64'(bif.in_ready), 64'd0);
        chk("bp_hold_a", bif.out_result, 64'hA);
        tick();
        chk("bp_in_ready_still_low", 64'(bif.in_ready), 64'd0);
        chk("bp_hold_a_2", bif.out_result, 64'hA);
        bif.out_ready = 1'b1;
        tick();
        chk("bp_out_b", bif.out_result, 64'hB);
        chk("bp_out_valid_b", 64'(bif.out_valid), 64'd1);
        chk("bp_in_ready_back", 64'(bif.in_ready), 64'd1);
        tick();
        chk("bp_done_out_valid", 64'(bif.out_valid), 64'd0);
`ifndef EXMEM_STALL_CNT_EN
        chk("stall_cnt_disabled", 64'(stall_cnt), 64'd0);
`endif

        // Flush with two entries held and an input presented in the flush cycle
        bif.out_ready = 1'b0;
        send(mk(64'hC, 1'b0, 64'h3, 5'd1, 4'h1));
        tick();
        send(mk(64'hD, 1'b1, 64'h4, 5'd2, 4'h2));
        tick();
        chk("fl_full_in_ready", 64'(bif.in_ready), 64'd0);
        flush = 1'b1;
        drive(mk(64'hE, 1'b0, 64'h5, 5'd3, 4'h3));
        tick();
        flush = 1'b0; idle_in();
        exp_q.delete();
        chk_empty_state("fl");
        bif.out_ready = 1'b1;
        tick(); tick();
        chk("fl_no_late_out", 64'(bif.out_valid), 64'd0);

        // Flush in the same cycle as a drain: the drained entry counts as consumed
        bif.out_ready = 1'b0;
        send(mk(64'hF, 1'b1, 64'h6, 5'd4, 4'h4));
        tick();
        bif.out_ready = 1'b1; flush = 1'b1;
        drive(mk(64'h10, 1'b0, 64'h7, 5'd5, 4'h5));
        tick();
        flush = 1'b0; idle_in();
        chk("fl_drain_consumed", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk_empty_state("fl_drain");

        // Reset together with flush, entries in flight
        bif.out_ready = 1'b0;
        send(mk(64'h11, 1'b1, 64'h8, 5'd6, 4'h6));
        tick();
        send(mk(64'h12, 1'b0, 64'h9, 5'd7, 4'h7));
        tick(); idle_in();
        reset = 1'b1; flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        exp_q.delete();
        chk_empty_state("rstfl");
        chk("rstfl_out_result", bif.out_result, 64'd0);
        chk("rstfl_out_rd_ctrl", 64'({bif.out_rd, bif.out_ctrl, bif.out_zero}), 64'd0);
        bif.out_ready = 1'b1;
        tick(); tick();
        chk("rstfl_no_pulse", 64'(bif.out_valid), 64'd0);

`ifdef EXMEM_STALL_CNT_EN
        // Saturating stall counter, immune to flush, cleared by reset
        bif.out_ready = 1'b0;
        send(mk(64'h13, 1'b0, 64'h0, 5'd8, 4'h8));
        tick(); idle_in();
        tick(); tick(); tick();
        chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
        for (int i = 0; i < 70000; i++) tick();
        chk("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("stall_cnt_after_flush", 64'(stall_cnt), 64'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stall_cnt_after_reset", 64'(stall_cnt), 64'd0);
`endif

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64: width of the ALU result and store data.
REQ-002 The module SHALL have parameter RD_W, default 5: width of the destination register index.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  the execute stage presents a result this cycle.
REQ-006 in_ready  output  1  the block accepts the presented result this cycle.
REQ-007 in_result  input  DATA_W  ALU result.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_store_data  input  DATA_W  register value for STUR.
REQ-010 in_rd  input  RD_W  destination register.
REQ-011 in_ctrl  input  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-012 flush  input  1  discard all held entries (branch taken).
REQ-013 out_valid  output  1  the memory stage is presented an entry.
REQ-014 out_ready  input  1  the memory stage consumes the entry this cycle.
REQ-015 The outputs out_result, out_zero, out_store_data, out_rd and out_ctrl SHALL mirror the corresponding in_* widths.
REQ-016 stall_cnt  output  16  count of back-pressure cycles (see Configuration).

Function
REQ-017 The block SHALL hold two entries: main (drives the out_* ports) and skid (overflow), each with its own valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, derived only from registered state with no combinational path from out_ready.
REQ-019 Accept SHALL occur when in_valid and in_ready are both high; drain SHALL occur when out_valid and out_ready are both high; out_valid SHALL equal main_valid.
REQ-020 When main is empty and an entry is accepted in cycle N, that entry SHALL appear with out_valid high in cycle N+1.
REQ-021 When main is full, it drains in the same cycle as an accept, and skid is empty, main SHALL load the new entry, sustaining one entry per cycle.
REQ-022 When main is full, it does not drain, and an entry is accepted, the entry SHALL go to skid, and in_ready SHALL be low from the next cycle.
REQ-023 When skid is full and main drains, main SHALL load skid, skid SHALL clear, and in_ready SHALL rise in the following cycle; no accept is possible in the draining cycle.
REQ-024 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush or reset.
REQ-025 out_* data SHALL remain stable while out_valid is high and out_ready is low.
REQ-026 The block SHALL pass all fields through unmodified; in particular in_zero SHALL NOT be recomputed.
REQ-027 flush high SHALL clear main_valid and skid_valid at the next edge. An entry accepted in the flush cycle SHALL be discarded. A drain in the flush cycle SHALL still count as consumed. in_ready SHALL be 1 in the following cycle.
REQ-028 When flush and reset are asserted together, reset SHALL take precedence; the results are identical.

Reset
REQ-029 While reset is high at an edge: main_valid=0, skid_valid=0, and all data registers=0.
REQ-030 After reset: out_valid=0, in_ready=1, out_* fields=0, stall_cnt=0.
REQ-031 Reset mid-transfer SHALL drop both held entries with no output pulse.

Configuration
REQ-032 With EXMEM_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 in each cycle where out_valid=1 and out_ready=0, saturating at 16'hFFFF. It SHALL be cleared by reset only, not by flush.
REQ-033 Without EXMEM_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-034 Reset, then in_valid=1 with in_result=64'h5, in_zero=0, out_ready=1 -> out_valid=1 and out_result=5 the next cycle; in_ready stays 1.
REQ-035 Stream 8 entries (results 1..8) back-to-back with out_ready=1 -> 8 consecutive out_valid cycles with results 1..8 in order.
REQ-036 Hold out_ready=0 and send results A then B -> in_ready drops after B; out_result holds A; raise out_ready -> A, then B; in_ready returns 1 one cycle after A drains.
REQ-037 Two entries held, assert flush for one cycle with in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the flush-cycle input never appears.
REQ-038 With EXMEM_STALL_CNT_EN defined, hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF; a subsequent flush leaves it unchanged and reset clears it to 0.
